// File: rtl/ber_ctrl_pkg.sv
// Shared definitions for the BER run controller: defaults, idle index and FSM states.
package ber_ctrl_pkg;
   localparam int N_PROB_DEF       = 84;
   localparam int PROB_W_DEF       = 32;
   localparam int CNT_W_DEF        = 64;
   localparam int DRAIN_CYCLES_DEF = 16;
   localparam int TBL_AW           = $clog2(N_PROB_DEF);

   localparam logic [31:0] PROB_IDX_IDLE = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } ber_state_t;
endpackage

// File: rtl/prob_table_ram.sv
// Probability table storage: simple dual-port, registered read, no reset so it maps onto block RAM.
module prob_table_ram #(
   parameter int DEPTH = 84,
   parameter int WIDTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/ber_run_controller.sv
// Sequences one BER run: stream the probability table under reset, run until a target or abort,
// freeze, drain the pipeline and snapshot the counters.
//   state  | meaning
//   IDLE   | no run yet or last run aborted during load; table writable
//   LOAD   | streaming table entries to the system, system held in reset
//   SETTLE | one idle-index cycle before releasing reset
//   RUN    | system enabled, thresholds compared each cycle
//   DRAIN  | enable dropped, waiting for the pipeline to empty
//   DONE   | results held; table writable, start re-runs
module ber_run_controller
   import ber_ctrl_pkg::*;
#(
   parameter int N_PROB       = N_PROB_DEF,
   parameter int PROB_W       = PROB_W_DEF,
   parameter int CNT_W        = CNT_W_DEF,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tbl_we,
   input  logic [6:0]        tbl_addr,
   input  logic [PROB_W-1:0] tbl_wdata,
   input  logic              start,
   input  logic              abort,
   input  logic              cfg_precode_en,
   input  logic [3:0]        cfg_n_interleave,
   input  logic [CNT_W-1:0]  max_bits,
   input  logic [CNT_W-1:0]  max_frame_errors,
   input  logic [CNT_W-1:0]  total_bits,
   input  logic [CNT_W-1:0]  total_bit_errors_pre,
   input  logic [CNT_W-1:0]  total_bit_errors_post,
   input  logic [CNT_W-1:0]  total_frames,
   input  logic [CNT_W-1:0]  total_frame_errors,
   output logic              sys_rstn,
   output logic              sys_en,
   output logic [31:0]       sys_prob_idx,
   output logic [63:0]       sys_prob_in,
   output logic              sys_precode_en,
   output logic [3:0]        sys_n_interleave,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [CNT_W-1:0]  res_bits,
   output logic [CNT_W-1:0]  res_err_pre,
   output logic [CNT_W-1:0]  res_err_post,
   output logic [CNT_W-1:0]  res_frames,
   output logic [CNT_W-1:0]  res_frame_err
);
   localparam int AW = $clog2(N_PROB);
   localparam int KW = $clog2(N_PROB + 1);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [KW-1:0] K_LAST     = KW'(N_PROB);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   ber_state_t state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic [31:0]       idx_q, idx_d;
   logic              pvalid_q, pvalid_d;
   logic              aborted_q, aborted_d;
   logic              precode_q, precode_d;
   logic [3:0]        nint_q, nint_d;
   logic [CNT_W-1:0]  bits_reg_q, ferr_reg_q;
   logic [CNT_W-1:0]  rb_q, rb_d, rpre_q, rpre_d, rpost_q, rpost_d, rfr_q, rfr_d, rfe_q, rfe_d;
   logic [PROB_W-1:0] rdata;
   logic              tbl_wr, thr_hit;

   assign tbl_wr = tbl_we && (state_q == ST_IDLE || state_q == ST_DONE) && (tbl_addr < 7'(N_PROB));

   prob_table_ram #(.DEPTH(N_PROB), .WIDTH(PROB_W), .AW(AW)) u_tbl (
      .clk   (clk),
      .we    (tbl_wr),
      .waddr (tbl_addr[AW-1:0]),
      .wdata (tbl_wdata),
      .raddr (k_q[AW-1:0]),
      .rdata (rdata)
   );

   // Compare against last cycle's counters so the wide compare has a full cycle.
   assign thr_hit = ((max_bits != '0) && (bits_reg_q >= max_bits)) ||
                    ((max_frame_errors != '0) && (ferr_reg_q >= max_frame_errors));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         k_q        <= '0;
         drain_q    <= '0;
         idx_q      <= PROB_IDX_IDLE;
         pvalid_q   <= 1'b0;
         aborted_q  <= 1'b0;
         precode_q  <= 1'b0;
         nint_q     <= 4'd1;
         bits_reg_q <= '0;
         ferr_reg_q <= '0;
         rb_q       <= '0;
         rpre_q     <= '0;
         rpost_q    <= '0;
         rfr_q      <= '0;
         rfe_q      <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         drain_q    <= drain_d;
         idx_q      <= idx_d;
         pvalid_q   <= pvalid_d;
         aborted_q  <= aborted_d;
         precode_q  <= precode_d;
         nint_q     <= nint_d;
         bits_reg_q <= total_bits;
         ferr_reg_q <= total_frame_errors;
         rb_q       <= rb_d;
         rpre_q     <= rpre_d;
         rpost_q    <= rpost_d;
         rfr_q      <= rfr_d;
         rfe_q      <= rfe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD;
         ST_LOAD:   if (abort) state_d = ST_IDLE;
                    else if (k_q == K_LAST) state_d = ST_SETTLE;
         ST_SETTLE: state_d = abort ? ST_IDLE : ST_RUN;
         ST_RUN:    if (abort || thr_hit) state_d = ST_DRAIN;
         ST_DRAIN:  if (drain_q == '0) state_d = ST_DONE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      k_d       = k_q;
      drain_d   = drain_q;
      idx_d     = PROB_IDX_IDLE;
      pvalid_d  = 1'b0;
      aborted_d = aborted_q;
      precode_d = precode_q;
      nint_d    = nint_q;
      rb_d      = rb_q;
      rpre_d    = rpre_q;
      rpost_d   = rpost_q;
      rfr_d     = rfr_q;
      rfe_d     = rfe_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               k_d       = '0;
               aborted_d = 1'b0;
               precode_d = cfg_precode_en;
               nint_d    = cfg_n_interleave;
            end
         end
         ST_LOAD: begin
            if (k_q != K_LAST) k_d = k_q + KW'(1);
            if (abort) aborted_d = 1'b1;
            // Index is registered alongside the RAM read so idx k lands with entry k.
            else if (k_q < K_LAST) begin
               idx_d    = 32'(k_q);
               pvalid_d = 1'b1;
            end
         end
         ST_SETTLE: if (abort) aborted_d = 1'b1;
         ST_RUN: begin
            drain_d = DRAIN_LOAD;
            if (abort) aborted_d = 1'b1;
         end
         ST_DRAIN: begin
            if (drain_q == '0) begin
               rb_d    = total_bits;
               rpre_d  = total_bit_errors_pre;
               rpost_d = total_bit_errors_post;
               rfr_d   = total_frames;
               rfe_d   = total_frame_errors;
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      sys_en   = (state_q == ST_RUN);
      sys_rstn = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_DONE);
      busy     = !((state_q == ST_IDLE) || (state_q == ST_DONE));
      done     = (state_q == ST_DONE);
   end

   assign sys_prob_idx     = idx_q;
   assign sys_prob_in      = pvalid_q ? {{(64-PROB_W){1'b0}}, rdata} : 64'd0;
   assign sys_precode_en   = precode_q;
   assign sys_n_interleave = nint_q;
   assign aborted          = aborted_q;
   assign res_bits         = rb_q;
   assign res_err_pre      = rpre_q;
   assign res_err_post     = rpost_q;
   assign res_frames       = rfr_q;
   assign res_frame_err    = rfe_q;
endmodule

// File: tb/tb_ber_run_controller.sv
// Bench for ber_run_controller: acts as the measured system and checks load, stop, drain and snapshot behaviour.
module tb_ber_run_controller;
   import ber_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst, tbl_we, start, abort, cfg_precode_en;
   logic [6:0]  tbl_addr;
   logic [31:0] tbl_wdata;
   logic [3:0]  cfg_n_interleave;
   logic [63:0] max_bits, max_frame_errors;
   logic [63:0] total_bits, total_bit_errors_pre, total_bit_errors_post, total_frames, total_frame_errors;
   logic        sys_rstn, sys_en, sys_precode_en, busy, done, aborted;
   logic [31:0] sys_prob_idx;
   logic [63:0] sys_prob_in;
   logic [3:0]  sys_n_interleave;
   logic [63:0] res_bits, res_err_pre, res_err_post, res_frames, res_frame_err;

   always #5 clk = ~clk;

   ber_run_controller dut (
      .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
      .start(start), .abort(abort), .cfg_precode_en(cfg_precode_en), .cfg_n_interleave(cfg_n_interleave),
      .max_bits(max_bits), .max_frame_errors(max_frame_errors),
      .total_bits(total_bits), .total_bit_errors_pre(total_bit_errors_pre),
      .total_bit_errors_post(total_bit_errors_post), .total_frames(total_frames),
      .total_frame_errors(total_frame_errors),
      .sys_rstn(sys_rstn), .sys_en(sys_en), .sys_prob_idx(sys_prob_idx), .sys_prob_in(sys_prob_in),
      .sys_precode_en(sys_precode_en), .sys_n_interleave(sys_n_interleave),
      .busy(busy), .done(done), .aborted(aborted),
      .res_bits(res_bits), .res_err_pre(res_err_pre), .res_err_post(res_err_post),
      .res_frames(res_frames), .res_frame_err(res_frame_err)
   );

   int checks = 0;
   int failures = 0;

   // System model: counters advance only while enabled, clear while held in reset.
   logic [63:0] m_bits, m_pre, m_post, m_frames, m_fe;
   int          en_cnt, inc_cfg, err_per;
   logic [63:0] bits_hist [0:8191];
   logic [63:0] fe_hist   [0:8191];
   logic [31:0] exp_tbl   [N_PROB_DEF];
   int          obs_en, obs_drain;
   logic        obs_ab;

   typedef struct {
      logic [63:0] maxb;
      logic [63:0] maxfe;
      int          inc;
      int          errp;
      int          abort_at;
      bit          poke;
      int          exp_en;
      logic [63:0] exp_bits;
      logic [63:0] exp_fe;
      bit          exp_ab;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (sys_rstn !== 1'b1) begin
         m_bits = 0; m_pre = 0; m_post = 0; m_frames = 0; m_fe = 0; en_cnt = 0;
      end else if (sys_en === 1'b1) begin
         en_cnt++;
         m_bits   += (inc_cfg == 0) ? 64'($urandom_range(1, 128)) : 64'(inc_cfg);
         m_frames += 64'd1;
         m_pre    += 64'($urandom_range(0, 3));
         m_post   += 64'($urandom_range(0, 1));
         if (err_per == 255) begin
            if ($urandom_range(0, 7) == 0) m_fe += 64'd1;
         end else if (err_per != 0 && (en_cnt % err_per) == 0) begin
            m_fe += 64'd1;
         end
         if (en_cnt < 8192) begin
            bits_hist[en_cnt] = m_bits;
            fe_hist[en_cnt]   = m_fe;
         end
      end
      total_bits = m_bits; total_bit_errors_pre = m_pre; total_bit_errors_post = m_post;
      total_frames = m_frames; total_frame_errors = m_fe;
   endtask

   // A threshold met by the counters of enabled cycle r stops the run after cycle r+1.
   function automatic int model_en(input logic [63:0] mb, input logic [63:0] mf, input int abort_at);
      int e;
      e = -1;
      for (int r = 1; r <= en_cnt && r < 8192; r++) begin
         if ((mb != 0 && bits_hist[r] >= mb) || (mf != 0 && fe_hist[r] >= mf)) begin
            e = r + 1;
            break;
         end
      end
      if (abort_at != 0 && (e < 0 || abort_at < e)) e = abort_at;
      return e;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_rstn"}, 64'(sys_rstn), 0);
      chk({tag, "_en"}, 64'(sys_en), 0);
      chk({tag, "_idx"}, 64'(sys_prob_idx), 64'hFFFF_FFFF);
      chk({tag, "_pin"}, sys_prob_in, 0);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_done"}, 64'(done), 0);
      chk({tag, "_aborted"}, 64'(aborted), 0);
      chk({tag, "_precode"}, 64'(sys_precode_en), 0);
      chk({tag, "_nint"}, 64'(sys_n_interleave), 1);
      chk({tag, "_res"}, res_bits | res_err_pre | res_err_post | res_frames | res_frame_err, 0);
   endtask

   task automatic do_run(input logic [63:0] maxb, input logic [63:0] maxfe, input int inc,
                         input int errp, input int abort_at, input bit poke);
      logic       pc;
      logic [3:0] ni;
      int         guard, d;
      inc_cfg = inc; err_per = errp; max_bits = maxb; max_frame_errors = maxfe;
      pc = 1'($urandom_range(0, 1));
      ni = 4'($urandom_range(0, 15));
      cfg_precode_en = pc; cfg_n_interleave = ni;
      start = 1'b1; tick(); start = 1'b0;
      cfg_precode_en = ~pc; cfg_n_interleave = ~ni;
      chk("load_entry_busy", 64'(busy), 1);
      chk("load_entry_aborted", 64'(aborted), 0);
      for (int i = 0; i < N_PROB_DEF; i++) begin
         tick();
         chk("load_idx", 64'(sys_prob_idx), 64'(i));
         chk("load_data", sys_prob_in, 64'(exp_tbl[i]));
         chk("load_rstn_en", {62'd0, sys_rstn, sys_en}, 0);
      end
      tick();
      chk("settle_idx", 64'(sys_prob_idx), 64'hFFFF_FFFF);
      chk("settle_rstn_en", {62'd0, sys_rstn, sys_en}, 0);
      tick();
      chk("run_rstn_en", {62'd0, sys_rstn, sys_en}, 3);
      chk("run_cfg", {59'd0, sys_precode_en, sys_n_interleave}, {59'd0, pc, ni});
      guard = 0;
      while (sys_en === 1'b1 && guard < 5000) begin
         if (abort_at != 0 && en_cnt == abort_at) abort = 1'b1;
         if (poke && en_cnt == 3) begin
            tbl_we = 1'b1; tbl_addr = 7'd5; tbl_wdata = 32'hDEAD_BEEF; start = 1'b1;
         end
         tick();
         abort = 1'b0; tbl_we = 1'b0; start = 1'b0;
         if (poke && en_cnt == 4) chk("start_while_busy", {62'd0, busy, sys_en}, 3);
         guard++;
      end
      chk("run_bounded", 64'(guard >= 5000), 0);
      d = 0;
      while (done !== 1'b1 && d < 100) begin
         d++;
         if (d == 1) chk("drain_rstn_en", {62'd0, sys_rstn, sys_en}, 2);
         tick();
      end
      obs_drain = d; obs_en = en_cnt; obs_ab = aborted;
      chk("drain_len", 64'(obs_drain), 64'(DRAIN_CYCLES_DEF));
      chk("res_bits", res_bits, m_bits);
      chk("res_pre", res_err_pre, m_pre);
      chk("res_post", res_err_post, m_post);
      chk("res_frames", res_frames, m_frames);
      chk("res_fe", res_frame_err, m_fe);
      chk("done_flags", {61'd0, busy, sys_rstn, sys_en}, 64'b010);
      chk("cfg_held", {59'd0, sys_precode_en, sys_n_interleave}, {59'd0, pc, ni});
   endtask

   initial begin
      vecs[0] = '{64'd1000, 64'd0, 64, 0,  0,  1'b0, 17,  64'd1088,  64'd0, 1'b0};
      vecs[1] = '{64'd0,    64'd3, 8,  10, 0,  1'b1, 31,  64'd248,   64'd3, 1'b0};
      vecs[2] = '{64'd64,   64'd0, 64, 0,  0,  1'b0, 2,   64'd128,   64'd0, 1'b0};
      vecs[3] = '{64'd500,  64'd2, 10, 5,  0,  1'b0, 11,  64'd110,   64'd2, 1'b0};
      vecs[4] = '{64'd0,    64'd0, 64, 0,  500, 1'b0, 500, 64'd32000, 64'd0, 1'b1};
      vecs[5] = '{64'd640,  64'd0, 64, 0,  11, 1'b0, 11,  64'd704,   64'd0, 1'b1};

      rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0; start = 1'b0; abort = 1'b0;
      cfg_precode_en = 1'b0; cfg_n_interleave = 4'd0; max_bits = '0; max_frame_errors = '0;
      inc_cfg = 0; err_per = 0;
      m_bits = 0; m_pre = 0; m_post = 0; m_frames = 0; m_fe = 0; en_cnt = 0;
      total_bits = 0; total_bit_errors_pre = 0; total_bit_errors_post = 0;
      total_frames = 0; total_frame_errors = 0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_reset("reset");

      for (int i = 0; i < N_PROB_DEF; i++) begin
         exp_tbl[i] = 32'(i + 1);
         tbl_we = 1'b1; tbl_addr = 7'(i); tbl_wdata = exp_tbl[i];
         tick();
      end
      tbl_addr = 7'd100; tbl_wdata = 32'h5555_5555;
      tick();
      tbl_we = 1'b0;

      for (int v = 0; v < 6; v++) begin
         do_run(vecs[v].maxb, vecs[v].maxfe, vecs[v].inc, vecs[v].errp, vecs[v].abort_at, vecs[v].poke);
         chk($sformatf("vec%0d_en_cycles", v), 64'(obs_en), 64'(vecs[v].exp_en));
         chk($sformatf("vec%0d_res_bits", v), res_bits, vecs[v].exp_bits);
         chk($sformatf("vec%0d_res_fe", v), res_frame_err, vecs[v].exp_fe);
         chk($sformatf("vec%0d_aborted", v), 64'(obs_ab), 64'(vecs[v].exp_ab));
      end

      // Table writes are accepted in DONE.
      for (int j = 0; j < 2; j++) begin
         tbl_we = 1'b1; tbl_addr = 7'(10 + 10 * j); tbl_wdata = $urandom();
         exp_tbl[10 + 10 * j] = tbl_wdata;
         tick();
      end
      tbl_we = 1'b0;

      // Abort during load at k=40.
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i <= 40; i++) tick();
      chk("abort_load_k", 64'(sys_prob_idx), 40);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_load_idx", 64'(sys_prob_idx), 64'hFFFF_FFFF);
      chk("abort_load_pin", sys_prob_in, 0);
      chk("abort_load_flags", {61'd0, busy, done, aborted}, 64'b001);

      // start together with abort in IDLE: start wins, then abort in SETTLE-free load.
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", {62'd0, busy, aborted}, 64'b10);
      tick();
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_load_early", {62'd0, busy, aborted}, 64'b01);

      for (int n = 0; n < 6; n++) begin
         logic [63:0] mb, mf;
         int e;
         mb = (n % 3 == 1) ? 64'd0 : 64'($urandom_range(200, 5000));
         mf = (n % 3 == 0) ? 64'd0 : 64'($urandom_range(1, 6));
         do_run(mb, mf, 0, 255, 0, 1'b0);
         e = model_en(mb, mf, 0);
         chk($sformatf("rand%0d_en_cycles", n), 64'(obs_en), 64'(e));
         chk($sformatf("rand%0d_aborted", n), 64'(obs_ab), 0);
      end

      // Reset in the middle of a run.
      max_bits = 0; max_frame_errors = 0; inc_cfg = 64; err_per = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int g = 0; g < 400 && en_cnt < 20; g++) tick();
      chk("midrun_reached", 64'(en_cnt), 20);
      rst = 1'b1; tick(); rst = 1'b0;
      check_reset("midrun_rst");
      do_run(64'd2000, 64'd0, 100, 0, 0, 1'b0);
      chk("post_rst_en_cycles", 64'(obs_en), 21);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
